// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC default,
// the canonical NOP encoding, FSM state encodings and a word-align helper.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
  localparam int          IMEM_AW_DEFAULT  = 14;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  // Redirect targets from EX are forced to a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Capture register for the instruction/PC pair presented on IF/ID at the
// moment a stall begins. While the stage is stalled the IMEM output may
// change, so IF/ID is served from here instead.
// clear has priority over load and also serves as the reset path.
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] capture_pc,
  input  logic [31:0] capture_inst,
  output logic [31:0] held_pc,
  output logic [31:0] held_inst,
  output logic        held_valid
);

  logic [63:0] data;

  // Valid bit: set on capture, dropped on clear (reset or flush).
  always_ff @(posedge clk) begin
    if (clear) begin
      held_valid <= 1'b0;
    end else if (load) begin
      held_valid <= 1'b1;
    end
  end

  // Payload: pc in the upper half, instruction in the lower half.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      data <= {capture_pc, capture_inst};
    end
  end

  assign held_pc   = data[63:32];
  assign held_inst = data[31:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, synchronous IMEM
// addressing and the IF/ID instruction/PC outputs.
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds fetch_count and
// bubble_count outputs.
//
// Control contract: there is no valid/ready handshake on this stage. The
// hazard unit drives ctrl_pc_en (0 = hold the current IF/ID contents) and
// ctrl_id_reg_flush (kill whatever IF/ID presents this cycle); if_id_valid
// qualifies if_id_inst in every cycle, and ID must ignore if_id_inst when
// if_id_valid is 0. A redirect (ctrl_pc_src) is only honoured in a cycle
// where ctrl_pc_en is 1.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = IMEM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_pc_en,
  input  logic               ctrl_imem_en,
  input  logic               ctrl_pc_src,
  input  logic               ctrl_id_reg_flush,
  input  logic [31:0]        pc_target,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_inst,
  output logic               if_id_valid,
  output logic [1:0]         fsm_state
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         advance;
  logic         bubble;
  logic         use_hold;
  logic         hold_load;
  logic         hold_clear;
  logic [31:0]  held_pc;
  logic [31:0]  held_inst;
  logic         held_valid;
  logic [31:0]  pres_pc;
  logic [31:0]  pres_inst;

  // The PC only moves once the boot cycle has issued the first IMEM read.
  assign advance = (state != ST_BOOT) && ctrl_pc_en;

  // Next-PC select; during reset the IMEM is pointed at the reset vector.
  always_comb begin
    next_pc = pc;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (advance) begin
      next_pc = ctrl_pc_src ? align_word(pc_target) : (pc + 32'd4);
    end
  end

  // IMEM is word addressed; the read issued this cycle returns next cycle,
  // when pc has become next_pc.
  assign imem_addr = next_pc[IMEM_AW+1:2];
  assign imem_en   = rst || (state == ST_BOOT) || ctrl_imem_en;

  // Bits of next_pc/pc_target that never reach IMEM or the PC register.
  logic unused_bits;
  assign unused_bits = ^{next_pc[31:IMEM_AW+2], next_pc[1:0], pc_target[1:0]};

  // PC and FSM state; reset returns to BOOT from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_BOOT;
    end else begin
      pc <= next_pc;
      case (state)
        ST_BOOT:  state <= ST_RUN;
        // A flush kills the presented instruction, so there is nothing
        // worth holding: stay in RUN even if the PC is stalled.
        ST_RUN:   state <= (!ctrl_pc_en && !ctrl_id_reg_flush) ? ST_STALL : ST_RUN;
        ST_STALL: state <= (ctrl_pc_en || ctrl_id_reg_flush) ? ST_RUN : ST_STALL;
        default:  state <= ST_BOOT;
      endcase
    end
  end

  assign fsm_state = state;

  // Capture the pair shown on IF/ID in the cycle the stall starts.
  assign hold_load  = !rst && (state == ST_RUN) && !ctrl_pc_en && !ctrl_id_reg_flush;
  assign hold_clear = rst || ctrl_id_reg_flush;

  fetch_hold_buffer u_hold (
    .clk          (clk),
    .load         (hold_load),
    .clear        (hold_clear),
    .capture_pc   (pc),
    .capture_inst (imem_dout),
    .held_pc      (held_pc),
    .held_inst    (held_inst),
    .held_valid   (held_valid)
  );

  // Source selection for IF/ID: bubble while booting, hold buffer while
  // stalled, otherwise the live IMEM read for the current pc.
  assign bubble    = rst || (state == ST_BOOT);
  assign use_hold  = (state == ST_STALL) && held_valid;
  assign pres_pc   = bubble ? RESET_PC : (use_hold ? held_pc : pc);
  assign pres_inst = use_hold ? held_inst : imem_dout;

  // Flush squashes the instruction but leaves the PC visible for debug.
  assign if_id_pc    = pres_pc;
  assign if_id_valid = !bubble && !ctrl_id_reg_flush;
  assign if_id_inst  = if_id_valid ? pres_inst : NOP_INST;

`ifdef FETCH_PERF_COUNTERS_EN
  // Distinct valid instructions (hold-buffer replays excluded) and bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (if_id_valid && !use_hold) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (!if_id_valid) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized control traffic, compared against a transaction-level model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ctrl_pc_en = 1'b0;
  logic        ctrl_imem_en = 1'b0;
  logic        ctrl_pc_src = 1'b0;
  logic        ctrl_id_reg_flush = 1'b0;
  logic [31:0] pc_target = 32'd0;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic [1:0]  fsm_state;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .ctrl_pc_en        (ctrl_pc_en),
    .ctrl_imem_en      (ctrl_imem_en),
    .ctrl_pc_src       (ctrl_pc_src),
    .ctrl_id_reg_flush (ctrl_id_reg_flush),
    .pc_target         (pc_target),
    .imem_en           (imem_en),
    .imem_addr         (imem_addr),
    .imem_dout         (imem_dout),
    .if_id_pc          (if_id_pc),
    .if_id_inst        (if_id_inst),
    .if_id_valid       (if_id_valid),
    .fsm_state         (fsm_state)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count       (fetch_count),
    .bubble_count      (bubble_count)
`endif
  );

  // ---------------- IMEM model (1-cycle read latency) ----------------
  logic [31:0] mem [0:16383];
  logic [31:0] imem_q;
  logic        garble_on = 1'b0;
  logic [31:0] garble_word = 32'd0;

  always @(posedge clk) if (imem_en) imem_q <= mem[imem_addr];
  assign imem_dout = garble_on ? garble_word : imem_q;

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // boot: first cycle after reset; frozen: IF/ID replays the pair that was
  // on display when the stall began.
  bit          m_boot;
  bit          m_frozen;
  logic [31:0] m_pc;
  logic [31:0] m_frz_pc;
  logic [31:0] m_frz_inst;
  logic [31:0] m_fetch;
  logic [31:0] m_bubble;

  logic [31:0] obs_pc;
  logic [31:0] obs_inst;
  logic        obs_valid;
  logic [1:0]  obs_state;

  task automatic model_reset();
    m_boot   = 1;
    m_frozen = 0;
    m_pc     = RST_PC;
    m_fetch  = 0;
    m_bubble = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1; ctrl_pc_en = 0; ctrl_imem_en = 0; ctrl_pc_src = 0;
      ctrl_id_reg_flush = 0; garble_on = 0;
      #1;
      check("rst_imem_en", {31'd0, imem_en}, 32'd1);
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);
      @(posedge clk);
    end
    #1 rst = 0;
    model_reset();
  endtask

  task automatic step(input logic pc_en, input logic ien, input logic src,
                      input logic flush, input logic [31:0] target);
    logic [31:0] p_pc, p_inst, e_inst, e_npc;
    logic        e_valid, e_en;
    logic [1:0]  e_state;
    @(negedge clk);
    ctrl_pc_en = pc_en; ctrl_imem_en = ien; ctrl_pc_src = src;
    ctrl_id_reg_flush = flush; pc_target = target;
    garble_on = !m_boot && m_frozen;
    garble_word = $urandom;
    #1;
    if (m_boot) begin
      p_pc = RST_PC; p_inst = NOP; e_state = ST_BOOT;
    end else if (m_frozen) begin
      p_pc = m_frz_pc; p_inst = m_frz_inst; e_state = ST_STALL;
    end else begin
      p_pc = m_pc; p_inst = mem[m_pc[15:2]]; e_state = ST_RUN;
    end
    e_valid = !m_boot && !flush;
    e_inst  = e_valid ? p_inst : NOP;
    e_en    = m_boot ? 1'b1 : ien;
    if (!m_boot && pc_en) e_npc = src ? {target[31:2], 2'b00} : m_pc + 32'd4;
    else                  e_npc = m_pc;

    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
    check("if_id_pc", if_id_pc, p_pc);
    check("if_id_inst", if_id_inst, e_inst);
    check("imem_en", {31'd0, imem_en}, {31'd0, e_en});
    check("imem_addr", {18'd0, imem_addr}, {18'd0, e_npc[15:2]});
    check("fsm_state", {30'd0, fsm_state}, {30'd0, e_state});
`ifdef FETCH_PERF_COUNTERS_EN
    check("fetch_count", fetch_count, m_fetch);
    check("bubble_count", bubble_count, m_bubble);
`endif
    obs_pc = if_id_pc; obs_inst = if_id_inst;
    obs_valid = if_id_valid; obs_state = fsm_state;

    // model update for the coming edge
    if (e_valid && !m_frozen) m_fetch = m_fetch + 1;
    if (!e_valid) m_bubble = m_bubble + 1;
    if (m_boot) begin
      m_boot = 0;
    end else begin
      if (!pc_en && !flush) begin
        if (!m_frozen) begin
          m_frz_pc = p_pc; m_frz_inst = p_inst;
        end
        m_frozen = 1;
      end else begin
        m_frozen = 0;
      end
      m_pc = e_npc;
    end
  endtask

  task automatic run_seq(input logic pc_en);
    step(pc_en, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;

    // Reset release and first fetches
    do_reset(2);
    run_seq(1'b1);
    check("tp_boot_valid", {31'd0, obs_valid}, 32'd0);
    run_seq(1'b1);
    check("tp_first_pc", obs_pc, 32'h4000_0000);
    check("tp_first_inst", obs_inst, 32'h0050_0093);
    run_seq(1'b1);
    check("tp_second_pc", obs_pc, 32'h4000_0004);
    check("tp_second_inst", obs_inst, 32'h0010_0113);

    // Three-cycle stall at 0x4000_0008 with garbage on IMEM
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("tp_stall_pc", obs_pc, 32'h4000_0008);
      check("tp_stall_inst", obs_inst, mem[2]);
    end
    run_seq(1'b1);
    check("tp_release_pc", obs_pc, 32'h4000_0008);
    check("tp_release_inst", obs_inst, mem[2]);
    run_seq(1'b1);
    check("tp_after_stall_pc", obs_pc, 32'h4000_000C);

    // Redirect to a misaligned target, killed instruction, then target
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0103);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h4000_0103);
    check("tp_redir_kill_valid", {31'd0, obs_valid}, 32'd0);
    check("tp_redir_kill_inst", obs_inst, NOP);
    run_seq(1'b1);
    check("tp_redir_pc", obs_pc, 32'h4000_0100);
    check("tp_redir_valid", {31'd0, obs_valid}, 32'd1);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    run_seq(1'b1);
    check("tp_wrap_top", obs_pc, 32'hFFFF_FFFC);
    run_seq(1'b1);
    check("tp_wrap_zero", obs_pc, 32'h0000_0000);

    // Flush during an active stall
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("tp_stall_flush_valid", {31'd0, obs_valid}, 32'd0);
    run_seq(1'b1);
    check("tp_stall_flush_state", {30'd0, obs_state}, {30'd0, ST_RUN});
    check("tp_stall_flush_next_valid", {31'd0, obs_valid}, 32'd1);

    // Reset pulse mid-stall
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    do_reset(1);
    run_seq(1'b1);
    check("tp_rst_boot_valid", {31'd0, obs_valid}, 32'd0);
    check("tp_rst_boot_pc", obs_pc, RST_PC);
`ifdef FETCH_PERF_COUNTERS_EN
    check("tp_rst_fetch_count", fetch_count, 32'd0);
    check("tp_rst_bubble_count", bubble_count, 32'd0);
`endif
    run_seq(1'b1);
    check("tp_rst_first_pc", obs_pc, RST_PC);
    check("tp_rst_first_inst", obs_inst, 32'h0050_0093);

    // Counter scenario: 10 fetches, 2-cycle stall, one flush
    do_reset(1);
    for (int i = 0; i < 10; i++) run_seq(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    run_seq(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
    run_seq(1'b1);
`ifdef FETCH_PERF_COUNTERS_EN
    check("tp_perf_fetch", fetch_count, 32'd10);
    check("tp_perf_bubble", bubble_count, 32'd2);
`endif

    // Randomized control traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      logic pe, ie, src, fl;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(1, 2));
      end else begin
        pe  = ($urandom_range(0, 9) < 8);
        ie  = pe ? 1'b1 : 1'($urandom_range(0, 1));
        src = ($urandom_range(0, 9) == 0);
        fl  = ($urandom_range(0, 9) == 0);
        step(pe, ie, src, fl, (r < 50) ? $urandom : (RST_PC | 32'($urandom_range(0, 1023))));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
